// File: rtl/rs_enc_frame_ctrl.sv
// ============================================================================
// Module   : rs_enc_frame_ctrl
// Purpose  : Frame sequencer for the GF(2^SYM_W) RS(N,K) encoder datapath.
//            Pulls K message symbols over valid/ready, drives the encoder
//            clear/shift/feedback-gate controls, flushes N-K parity symbols
//            through the output mux and frames the codeword with sof/eof/done.
// Options  : `define RS_ENC_CTRL_ABORT_EN adds the abort input and the
//            aborted output (frame abandon with encoder clear).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_enc_frame_ctrl #(
   parameter int N     = 15,
   parameter int K     = 11,
   parameter int SYM_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       src_valid,
   output logic       src_ready,
   output logic       enc_clr,
   output logic       enc_shift,
   output logic       enc_fb_en,
   output logic       out_sel,
   output logic       out_valid,
   output logic       sof,
   output logic       eof,
   output logic       busy,
   output logic       done,
   output logic [7:0] sym_idx
`ifdef RS_ENC_CTRL_ABORT_EN
   ,input  logic      abort
   ,output logic      aborted
`endif
);

   localparam int             CW       = $clog2(N);
   localparam logic [CW-1:0]  MSG_LAST = CW'(K - 1);
   localparam logic [CW-1:0]  PAR_LAST = CW'(N - K - 1);
   localparam logic [7:0]     K_BASE   = 8'(K);

   // Reject illegal geometries at elaboration time.
   if (N < 2 || N > 255 || K < 1 || K >= N || SYM_W < 1) begin : g_param_check
      $error("rs_enc_frame_ctrl: illegal N/K/SYM_W combination");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MSG   = 3'd2,
      S_PAR   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           w_hs;

   // State and phase counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and output decode from registered state, count and src_valid.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_hs      = 1'b0;
      src_ready = 1'b0;
      enc_clr   = 1'b0;
      enc_shift = 1'b0;
      enc_fb_en = 1'b0;
      out_sel   = 1'b0;
      out_valid = 1'b0;
      sof       = 1'b0;
      eof       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      sym_idx   = 8'd0;
`ifdef RS_ENC_CTRL_ABORT_EN
      aborted   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end

         S_CLEAR: begin
            busy    = 1'b1;
            enc_clr = 1'b1;
            state_d = S_MSG;
            cnt_d   = '0;
         end

         S_MSG: begin
            busy      = 1'b1;
            src_ready = 1'b1;
            enc_fb_en = 1'b1;
            sym_idx   = 8'(cnt_q);
            w_hs      = src_valid;
            if (w_hs) begin
               enc_shift = 1'b1;
               out_valid = 1'b1;
               sof       = (cnt_q == '0);
               if (cnt_q == MSG_LAST) begin
                  state_d = S_PAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end

         S_PAR: begin
            busy      = 1'b1;
            enc_shift = 1'b1;
            out_sel   = 1'b1;
            out_valid = 1'b1;
            sym_idx   = K_BASE + 8'(cnt_q);
            if (cnt_q == PAR_LAST) begin
               eof     = 1'b1;
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef RS_ENC_CTRL_ABORT_EN
      // Abort wins over any same-cycle handshake: nothing is consumed or
      // emitted, the encoder is cleared and the frame returns to IDLE.
      if (abort && (state_q == S_CLEAR || state_q == S_MSG || state_q == S_PAR)) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         w_hs      = 1'b0;
         enc_clr   = 1'b1;
         aborted   = 1'b1;
         src_ready = 1'b0;
         enc_shift = 1'b0;
         enc_fb_en = 1'b0;
         out_sel   = 1'b0;
         out_valid = 1'b0;
         sof       = 1'b0;
         eof       = 1'b0;
         sym_idx   = 8'd0;
      end
`endif
   end

endmodule

`default_nettype wire
